// File: rtl/branch_ctrl_if.sv
// ---------------------------------------------------------------------------
// definitions / branch_ctrl_if
//
// definitions : opcode constants shared by the decoder, the ALU and the
//               branch/PC stage (5-bit opcode space).
// branch_ctrl_if : bundle of the execute-stage signals seen by branch_ctrl.
//   Driven by the datapath (master):
//     start     one-cycle pulse, begin execution at PC 0 from IDLE or HALT
//     halt_req  decoded halt instruction in the current cycle
//     stall     hold PC and flags this cycle
//     op        opcode of the instruction in execute
//     alu_z     ALU equal flag
//     alu_lt    ALU less-than flag
//     alu_co    ALU carry-out
//     target    absolute branch target (PC_W bits)
//   Driven by branch_ctrl (slave):
//     pc        registered program counter (PC_W bits)
//     flag_z, flag_lt, flag_c  registered condition flags
//     taken     combinational branch-redirect indication
//     running   registered, core is in RUN
//     done      registered, core is in HALT
// ---------------------------------------------------------------------------
package definitions;
    localparam logic [4:0] kADD = 5'd0;
    localparam logic [4:0] kSUB = 5'd1;
    localparam logic [4:0] kCMP = 5'd2;
    localparam logic [4:0] kMOV = 5'd3;
    localparam logic [4:0] kAND = 5'd4;
    localparam logic [4:0] kOR  = 5'd5;
    localparam logic [4:0] kLD  = 5'd6;
    localparam logic [4:0] kST  = 5'd7;
    localparam logic [4:0] kBE  = 5'd8;
    localparam logic [4:0] kBL  = 5'd9;
    localparam logic [4:0] kBG  = 5'd10;
    localparam logic [4:0] kBA  = 5'd11;
    localparam logic [4:0] kHLT = 5'd12;
endpackage

interface branch_ctrl_if #(
    parameter int PC_W = 10
);
    logic            start;
    logic            halt_req;
    logic            stall;
    logic [4:0]      op;
    logic            alu_z;
    logic            alu_lt;
    logic            alu_co;
    logic [PC_W-1:0] target;

    logic [PC_W-1:0] pc;
    logic            flag_z;
    logic            flag_lt;
    logic            flag_c;
    logic            taken;
    logic            running;
    logic            done;

    modport master (
        output start, halt_req, stall, op, alu_z, alu_lt, alu_co, target,
        input  pc, flag_z, flag_lt, flag_c, taken, running, done
    );

    modport slave (
        input  start, halt_req, stall, op, alu_z, alu_lt, alu_co, target,
        output pc, flag_z, flag_lt, flag_c, taken, running, done
    );
endinterface

// File: rtl/branch_ctrl.sv
// ---------------------------------------------------------------------------
// branch_ctrl
//
// Program-counter and branch-resolution stage behind the ALU. Latches the
// ALU condition outputs into a flag register, chooses PC+1 or the branch
// target each cycle, and sequences the IDLE -> RUN -> HALT lifecycle.
//
// Ports:
//   clk    system clock, all state updates on the rising edge
//   reset  synchronous, active-high reset
//   bus    branch_ctrl_if.slave (see branch_ctrl_if.sv for the signal list)
//
// The PC_W parameter must match the PC_W of the connected interface.
// ---------------------------------------------------------------------------
module branch_ctrl
    import definitions::*;
#(
    parameter int PC_W = 10
) (
    input  logic          clk,
    input  logic          reset,
    branch_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            flag_z_q, flag_z_d;
    logic            flag_lt_q, flag_lt_d;
    logic            flag_c_q, flag_c_d;
    logic            running_q, done_q;

    logic            cond_met;
    logic            taken;

    // Branch condition is evaluated on the registered flags only, so a CMP
    // in the previous cycle feeds a branch this cycle with no bubble.
    always_comb begin
        cond_met = 1'b0;
        unique case (bus.op)
            kBE:     cond_met = flag_z_q;
            kBL:     cond_met = flag_lt_q;
            kBG:     cond_met = !flag_z_q && !flag_lt_q;
            kBA:     cond_met = 1'b1;
            default: cond_met = 1'b0;
        endcase
    end

    // A halting or stalled instruction never redirects the PC.
    assign taken = (state_q == S_RUN) && !bus.stall && !bus.halt_req && cond_met;

    // Next-state / next-PC / next-flag logic.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        flag_z_d  = flag_z_q;
        flag_lt_d = flag_lt_q;
        flag_c_d  = flag_c_q;

        unique case (state_q)
            S_IDLE: begin
                pc_d = '0;
                if (bus.start) begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                // start is ignored here; halt beats stall beats branch.
                if (bus.halt_req) begin
                    state_d = S_HALT;
                end else if (!bus.stall) begin
                    // PC+1 wraps naturally at 2**PC_W.
                    pc_d = taken ? bus.target : pc_q + 1'b1;
                    if (bus.op == kCMP) begin
                        flag_z_d  = bus.alu_z;
                        flag_lt_d = bus.alu_lt;
                    end else if (bus.op == kADD || bus.op == kSUB) begin
                        flag_c_d  = bus.alu_co;
                    end
                end
            end

            S_HALT: begin
                // Restart is a fresh run: PC back to 0 and stale flags dropped.
                if (bus.start) begin
                    state_d   = S_RUN;
                    pc_d      = '0;
                    flag_z_d  = 1'b0;
                    flag_lt_d = 1'b0;
                    flag_c_d  = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
                pc_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            flag_z_q  <= 1'b0;
            flag_lt_q <= 1'b0;
            flag_c_q  <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            flag_z_q  <= flag_z_d;
            flag_lt_q <= flag_lt_d;
            flag_c_q  <= flag_c_d;
            // Status bits registered from the next state so they track
            // state_q exactly without a decode on the output path.
            running_q <= (state_d == S_RUN);
            done_q    <= (state_d == S_HALT);
        end
    end

    assign bus.pc      = pc_q;
    assign bus.flag_z  = flag_z_q;
    assign bus.flag_lt = flag_lt_q;
    assign bus.flag_c  = flag_c_q;
    assign bus.taken   = taken;
    assign bus.running = running_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_ctrl
//
// Drives branch_ctrl through directed scenarios (start-up, compare/branch,
// wrap, stall, halt/restart, reset mid-run) followed by random stimulus.
// A behavioural model of the PC stage predicts every output; a compare
// process checks it each cycle at the falling edge, and literal
// expectations in the directed part pin the model itself.
// ---------------------------------------------------------------------------
module tb_branch_ctrl;
    import definitions::*;

    localparam int PC_W  = 10;
    localparam int PC_MOD = 1 << PC_W;

    logic clk;
    logic reset;
    logic chk_en;

    int n_checks;
    int n_fail;

    branch_ctrl_if #(.PC_W(PC_W)) bus ();

    branch_ctrl #(.PC_W(PC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    int m_mode;
    int m_pc;
    bit m_z, m_lt, m_c;

    function automatic bit branch_wanted(logic [4:0] o, bit z, bit lt);
        if (o == kBE) return z;
        if (o == kBL) return lt;
        if (o == kBG) return (!z && !lt);
        if (o == kBA) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_taken();
        return (m_mode == M_RUN) && !bus.stall && !bus.halt_req &&
               branch_wanted(bus.op, m_z, m_lt);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_mode = M_IDLE; m_pc = 0; m_z = 0; m_lt = 0; m_c = 0;
        end else if (m_mode == M_IDLE) begin
            if (bus.start) m_mode = M_RUN;
        end else if (m_mode == M_HALT) begin
            if (bus.start) begin
                m_mode = M_RUN; m_pc = 0; m_z = 0; m_lt = 0; m_c = 0;
            end
        end else begin
            if (bus.halt_req) begin
                m_mode = M_HALT;
            end else if (!bus.stall) begin
                if (exp_taken()) m_pc = int'(bus.target);
                else             m_pc = (m_pc + 1) % PC_MOD;
                if (bus.op == kCMP) begin
                    m_z = bus.alu_z; m_lt = bus.alu_lt;
                end else if (bus.op == kADD || bus.op == kSUB) begin
                    m_c = bus.alu_co;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc",      int'(bus.pc),      m_pc);
            chk("flag_z",  int'(bus.flag_z),  int'(m_z));
            chk("flag_lt", int'(bus.flag_lt), int'(m_lt));
            chk("flag_c",  int'(bus.flag_c),  int'(m_c));
            chk("running", int'(bus.running), int'(m_mode == M_RUN));
            chk("done",    int'(bus.done),    int'(m_mode == M_HALT));
            chk("taken",   int'(bus.taken),   int'(exp_taken()));
        end
    end

    // Apply one cycle of inputs and return at the falling edge of that cycle.
    task automatic step(input bit r, input bit st, input bit hr, input bit sl,
                        input logic [4:0] o, input bit z, input bit lt,
                        input bit co, input int tg, input bit verbose);
        @(posedge clk);
        #1;
        reset        = r;
        bus.start    = st;
        bus.halt_req = hr;
        bus.stall    = sl;
        bus.op       = o;
        bus.alu_z    = z;
        bus.alu_lt   = lt;
        bus.alu_co   = co;
        bus.target   = tg[PC_W-1:0];
        @(negedge clk);
        if (verbose)
            $display("txn rst=%0b start=%0b halt=%0b stall=%0b op=%0d z=%0b lt=%0b co=%0b tgt=%0d | pc=%0d taken=%0b run=%0b done=%0b flags z%0b lt%0b c%0b",
                     r, st, hr, sl, o, z, lt, co, tg, bus.pc, bus.taken,
                     bus.running, bus.done, bus.flag_z, bus.flag_lt, bus.flag_c);
    endtask

    task automatic nop(input bit verbose);
        step(0, 0, 0, 0, kMOV, 0, 0, 0, 0, verbose);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        chk_en   = 1'b0;
        reset    = 1'b1;
        bus.start = 0; bus.halt_req = 0; bus.stall = 0; bus.op = kMOV;
        bus.alu_z = 0; bus.alu_lt = 0; bus.alu_co = 0; bus.target = '0;

        step(1, 0, 0, 0, kMOV, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, kMOV, 0, 0, 0, 0, 1);
        chk_en = 1'b1;

        // Reset state, then start and sequential fetch.
        nop(1);
        chk("rst_pc", int'(bus.pc), 0);
        chk("rst_running", int'(bus.running), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_taken", int'(bus.taken), 0);
        step(0, 1, 0, 0, kMOV, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, kADD, 0, 0, 0, 0, 1);
            chk("seq_pc", int'(bus.pc), i);
            chk("seq_running", int'(bus.running), 1);
        end
        chk("seq_flag_c", int'(bus.flag_c), 0);
        step(0, 0, 0, 0, kADD, 0, 0, 0, 0, 1);             // pc 4

        // Compare then BE, taken.
        step(0, 0, 0, 0, kCMP, 1, 0, 0, 0, 1);
        chk("cmp_pc5", int'(bus.pc), 5);
        step(0, 0, 0, 0, kBE, 0, 0, 0, 40, 1);
        chk("be_taken", int'(bus.taken), 1);
        step(0, 0, 0, 0, kBA, 0, 0, 0, 5, 1);
        chk("be_pc40", int'(bus.pc), 40);
        // Compare with z=0, BE not taken.
        step(0, 0, 0, 0, kCMP, 0, 0, 0, 0, 1);
        chk("cmp2_pc5", int'(bus.pc), 5);
        step(0, 0, 0, 0, kBE, 0, 0, 0, 40, 1);
        chk("be_not_taken", int'(bus.taken), 0);
        // BG vs BL with lt=1.
        step(0, 0, 0, 0, kCMP, 0, 1, 0, 0, 1);
        chk("be_pc7", int'(bus.pc), 7);
        step(0, 0, 0, 0, kBG, 0, 0, 0, 50, 1);
        chk("bg_not_taken", int'(bus.taken), 0);
        step(0, 0, 0, 0, kBL, 0, 0, 0, 100, 1);
        chk("bl_taken", int'(bus.taken), 1);
        chk("bl_pc9", int'(bus.pc), 9);
        step(0, 0, 0, 0, kCMP, 0, 0, 0, 0, 1);
        chk("bl_pc100", int'(bus.pc), 100);
        step(0, 0, 0, 0, kBG, 0, 0, 0, 200, 1);
        chk("bg_taken", int'(bus.taken), 1);

        // Wrap at 2**PC_W-1.
        step(0, 0, 0, 0, kBA, 0, 0, 0, 1023, 1);
        chk("bg_pc200", int'(bus.pc), 200);
        nop(1);
        chk("pc_max", int'(bus.pc), 1023);
        nop(1);
        chk("pc_wrap", int'(bus.pc), 0);

        // Stall for 3 cycles at pc 12 with a CMP that must not land.
        step(0, 0, 0, 0, kBA, 0, 0, 0, 12, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, kCMP, 1, 1, 0, 0, 1);
            chk("stall_pc", int'(bus.pc), 12);
            chk("stall_taken", int'(bus.taken), 0);
        end
        nop(1);
        chk("unstall_pc", int'(bus.pc), 12);
        chk("stall_flag_z", int'(bus.flag_z), 0);

        // Halt at pc 30 with flag_z set, then restart.
        step(0, 0, 0, 0, kCMP, 1, 0, 0, 0, 1);
        chk("pre_halt_pc13", int'(bus.pc), 13);
        step(0, 0, 0, 0, kBA, 0, 0, 0, 30, 1);
        step(0, 0, 1, 0, kBA, 0, 0, 0, 60, 1);
        chk("halt_pc30", int'(bus.pc), 30);
        chk("halt_taken", int'(bus.taken), 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, kBA, 0, 0, 0, 60, 1);
            chk("halt_done", int'(bus.done), 1);
            chk("halt_hold_pc", int'(bus.pc), 30);
            chk("halt_taken_off", int'(bus.taken), 0);
        end
        chk("halt_flag_z", int'(bus.flag_z), 1);
        step(0, 1, 0, 0, kMOV, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, kADD, 0, 0, 1, 0, 1);
        chk("restart_pc", int'(bus.pc), 0);
        chk("restart_running", int'(bus.running), 1);
        chk("restart_flag_z", int'(bus.flag_z), 0);
        step(0, 1, 0, 0, kADD, 0, 0, 0, 0, 1);             // start ignored
        chk("run_start_pc", int'(bus.pc), 1);
        chk("add_flag_c", int'(bus.flag_c), 1);

        // Reset mid-run at pc 17 with flag_z=1, start in the same cycle.
        step(0, 0, 0, 0, kBA, 0, 0, 0, 16, 1);
        step(0, 0, 0, 0, kCMP, 1, 0, 0, 0, 1);
        step(1, 1, 0, 0, kADD, 0, 0, 1, 0, 1);
        chk("pre_rst_pc17", int'(bus.pc), 17);
        chk("pre_rst_flag_z", int'(bus.flag_z), 1);
        nop(1);
        chk("mid_rst_pc", int'(bus.pc), 0);
        chk("mid_rst_flag_z", int'(bus.flag_z), 0);
        chk("mid_rst_running", int'(bus.running), 0);
        nop(1);
        chk("mid_rst_idle", int'(bus.running), 0);

        // Random phase.
        step(0, 1, 0, 0, kMOV, 0, 0, 0, 0, 1);
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 59) == 0,
                 $urandom_range(0, 5) == 0,
                 5'($urandom_range(0, 15)),
                 1'($urandom), 1'($urandom), 1'($urandom),
                 int'($urandom_range(0, PC_MOD - 1)), 1);
        end

        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
